// File: rtl/tdm_mux.sv
// rtl/tdm_mux.sv - registered N-channel mux with manual select and time-division scan mode
// Outputs are pure registers; scan counters freeze while e is low.
module tdm_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1,
  localparam int SW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SW-1:0]             s,
  input  logic                      e,
  input  logic                      mode,
  output logic [WIDTH-1:0]          y,
  output logic [SW-1:0]             y_ch,
  output logic                      valid,
  output logic                      sof
);

  localparam int            DW_W    = $clog2(DWELL) + 1;
  localparam logic [SW:0]   CH_LIM  = (SW+1)'(CHANNELS);
  localparam logic [SW-1:0] LAST_CH = SW'(CHANNELS - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  logic [SW-1:0]    ch_q, ch_d;
  logic [DW_W-1:0]  dw_q, dw_d;
  logic [WIDTH-1:0] y_d;
  logic [SW-1:0]    y_ch_d;
  logic             valid_d, sof_d;

  logic [WIDTH-1:0] ch_data [CHANNELS];
  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] sel_data;
  logic             s_ok;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign ch_data[g] = d[g*WIDTH +: WIDTH];
  end

  assign sel  = mode ? ch_q : s;
  assign s_ok = ({1'b0, s} < CH_LIM);

  // Explicit compare loop keeps out-of-range selects (non-power-of-2 counts) at zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == i[SW-1:0]) sel_data = ch_data[i];
    end
  end

  always_comb begin
    y_d     = '0;
    y_ch_d  = y_ch;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    ch_d    = ch_q;
    dw_d    = dw_q;
    if (e) begin
      if (!mode) begin
        dw_d = '0;
        if (s_ok) begin
          y_d     = sel_data;
          y_ch_d  = s;
          valid_d = 1'b1;
          ch_d    = s;
        end
      end else begin
        y_d     = sel_data;
        y_ch_d  = ch_q;
        valid_d = 1'b1;
        sof_d   = (ch_q == '0) && (dw_q == '0);
        if (dw_q == DW_LAST) begin
          dw_d = '0;
          ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
        end else begin
          dw_d = dw_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      y_ch  <= '0;
      valid <= 1'b0;
      sof   <= 1'b0;
      ch_q  <= '0;
      dw_q  <= '0;
    end else begin
      y     <= y_d;
      y_ch  <= y_ch_d;
      valid <= valid_d;
      sof   <= sof_d;
      ch_q  <= ch_d;
      dw_q  <= dw_d;
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// tb/tb_tdm_mux.sv - directed bench for tdm_mux
// Instance a: 4 channels, dwell 1. Instance b: 3 channels, dwell 2.
module tb_tdm_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] d_a = {8'h44, 8'h33, 8'h22, 8'h11};
  logic [1:0]  s_a = '0;
  logic        e_a = 1'b0, mode_a = 1'b0;
  logic [7:0]  y_a;
  logic [1:0]  y_ch_a;
  logic        valid_a, sof_a;

  logic [23:0] d_b = {8'hcc, 8'hbb, 8'haa};
  logic [1:0]  s_b = '0;
  logic        e_b = 1'b0, mode_b = 1'b0;
  logic [7:0]  y_b;
  logic [1:0]  y_ch_b;
  logic        valid_b, sof_b;

  int n_checks = 0;
  int n_fail = 0;

  tdm_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .d(d_a), .s(s_a), .e(e_a), .mode(mode_a),
    .y(y_a), .y_ch(y_ch_a), .valid(valid_a), .sof(sof_a)
  );

  tdm_mux #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .d(d_b), .s(s_b), .e(e_b), .mode(mode_b),
    .y(y_b), .y_ch(y_ch_b), .valid(valid_b), .sof(sof_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    n_checks++;
    if ({y_a, y_ch_a, valid_a, sof_a} !== 12'h000) begin
      $display("FAIL reset_a: got %h want 000", {y_a, y_ch_a, valid_a, sof_a});
      n_fail++;
    end
    n_checks++;
    if ({y_b, y_ch_b, valid_b, sof_b} !== 12'h000) begin
      $display("FAIL reset_b: got %h want 000", {y_b, y_ch_b, valid_b, sof_b});
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    logic [7:0] exp_y [4];
    exp_y[0] = 8'h11; exp_y[1] = 8'h22; exp_y[2] = 8'h33; exp_y[3] = 8'h44;
    e_a = 1'b1; mode_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_a = 2'(i);
      step();
      n_checks++;
      if ({y_a, y_ch_a, valid_a, sof_a} !== {exp_y[i], 2'(i), 1'b1, 1'b0}) begin
        $display("FAIL manual_s%0d: got %h want %h", i, {y_a, y_ch_a, valid_a, sof_a},
                 {exp_y[i], 2'(i), 1'b1, 1'b0});
        n_fail++;
      end
    end
    e_a = 1'b0;
    step();
    n_checks++;
    if ({y_a, y_ch_a, valid_a, sof_a} !== {8'h00, 2'd3, 1'b0, 1'b0}) begin
      $display("FAIL manual_disable: got %h want %h", {y_a, y_ch_a, valid_a, sof_a},
               {8'h00, 2'd3, 1'b0, 1'b0});
      n_fail++;
    end
  endtask

  task automatic test_out_of_range();
    e_b = 1'b1; mode_b = 1'b0; s_b = 2'd1;
    step();
    n_checks++;
    if ({y_b, y_ch_b, valid_b, sof_b} !== {8'hbb, 2'd1, 1'b1, 1'b0}) begin
      $display("FAIL oor_pre: got %h want %h", {y_b, y_ch_b, valid_b, sof_b},
               {8'hbb, 2'd1, 1'b1, 1'b0});
      n_fail++;
    end
    s_b = 2'd3;
    step();
    n_checks++;
    if ({y_b, y_ch_b, valid_b, sof_b} !== {8'h00, 2'd1, 1'b0, 1'b0}) begin
      $display("FAIL oor_s3: got %h want %h", {y_b, y_ch_b, valid_b, sof_b},
               {8'h00, 2'd1, 1'b0, 1'b0});
      n_fail++;
    end
  endtask

  task automatic test_scan_dwell();
    logic [1:0] exp_ch [8];
    logic       exp_sof [8];
    logic [7:0] exp_y;
    exp_ch[0] = 0; exp_ch[1] = 0; exp_ch[2] = 1; exp_ch[3] = 1;
    exp_ch[4] = 2; exp_ch[5] = 2; exp_ch[6] = 0; exp_ch[7] = 0;
    for (int i = 0; i < 8; i++) exp_sof[i] = (i == 0 || i == 6);
    s_b = 2'd0; mode_b = 1'b0;
    step();
    mode_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_y = (exp_ch[i] == 0) ? 8'haa : (exp_ch[i] == 1) ? 8'hbb : 8'hcc;
      n_checks++;
      if ({y_b, y_ch_b, valid_b, sof_b} !== {exp_y, exp_ch[i], 1'b1, exp_sof[i]}) begin
        $display("FAIL scan_dwell_%0d: got %h want %h", i, {y_b, y_ch_b, valid_b, sof_b},
                 {exp_y, exp_ch[i], 1'b1, exp_sof[i]});
        n_fail++;
      end
    end
  endtask

  task automatic test_freeze();
    logic [1:0] exp_ch [3];
    logic [7:0] exp_y [3];
    exp_ch[0] = 1; exp_ch[1] = 1; exp_ch[2] = 2;
    exp_y[0] = 8'hbb; exp_y[1] = 8'hbb; exp_y[2] = 8'hcc;
    e_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({y_b, valid_b, sof_b} !== 10'h000) begin
        $display("FAIL freeze_off_%0d: got %h want 000", i, {y_b, valid_b, sof_b});
        n_fail++;
      end
    end
    e_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({y_b, y_ch_b, valid_b, sof_b} !== {exp_y[i], exp_ch[i], 1'b1, 1'b0}) begin
        $display("FAIL freeze_resume_%0d: got %h want %h", i, {y_b, y_ch_b, valid_b, sof_b},
                 {exp_y[i], exp_ch[i], 1'b1, 1'b0});
        n_fail++;
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [1:0] exp_ch [3];
    logic [7:0] exp_y [3];
    exp_ch[0] = 2; exp_ch[1] = 2; exp_ch[2] = 0;
    exp_y[0] = 8'hcc; exp_y[1] = 8'hcc; exp_y[2] = 8'haa;
    mode_b = 1'b0; s_b = 2'd2;
    step();
    mode_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({y_b, y_ch_b, valid_b, sof_b} !== {exp_y[i], exp_ch[i], 1'b1, i == 2}) begin
        $display("FAIL m2s_%0d: got %h want %h", i, {y_b, y_ch_b, valid_b, sof_b},
                 {exp_y[i], exp_ch[i], 1'b1, i == 2});
        n_fail++;
      end
    end
    mode_b = 1'b0; s_b = 2'd1;
    step();
    n_checks++;
    if ({y_b, y_ch_b, valid_b, sof_b} !== {8'hbb, 2'd1, 1'b1, 1'b0}) begin
      $display("FAIL s2m: got %h want %h", {y_b, y_ch_b, valid_b, sof_b},
               {8'hbb, 2'd1, 1'b1, 1'b0});
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ch [6];
    logic [7:0] exp_y;
    exp_ch[0] = 3; exp_ch[1] = 0; exp_ch[2] = 1;
    exp_ch[3] = 2; exp_ch[4] = 3; exp_ch[5] = 0;
    e_a = 1'b1; mode_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_y = 8'h11 * (8'(exp_ch[i]) + 8'd1);
      n_checks++;
      if ({y_a, y_ch_a, valid_a, sof_a} !== {exp_y, exp_ch[i], 1'b1, exp_ch[i] == 2'd0}) begin
        $display("FAIL b2b_%0d: got %h want %h", i, {y_a, y_ch_a, valid_a, sof_a},
                 {exp_y, exp_ch[i], 1'b1, exp_ch[i] == 2'd0});
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    e_b = 1'b1; mode_b = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({y_a, y_ch_a, valid_a, sof_a, y_b, y_ch_b, valid_b, sof_b} !== 24'h0) begin
      $display("FAIL mid_reset: got %h want 000000",
               {y_a, y_ch_a, valid_a, sof_a, y_b, y_ch_b, valid_b, sof_b});
      n_fail++;
    end
    #1 rst_n = 1'b1;
    step();
    n_checks++;
    if ({y_a, y_ch_a, valid_a, sof_a} !== {8'h11, 2'd0, 1'b1, 1'b1}) begin
      $display("FAIL post_reset_a: got %h want %h", {y_a, y_ch_a, valid_a, sof_a},
               {8'h11, 2'd0, 1'b1, 1'b1});
      n_fail++;
    end
    n_checks++;
    if ({y_b, y_ch_b, valid_b, sof_b} !== {8'haa, 2'd0, 1'b1, 1'b1}) begin
      $display("FAIL post_reset_b: got %h want %h", {y_b, y_ch_b, valid_b, sof_b},
               {8'haa, 2'd0, 1'b1, 1'b1});
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_out_of_range();
    test_scan_dwell();
    test_freeze();
    test_mode_switch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
